w_regfile: RTL and testbench

- Write-back stage of the Y86 pipeline. It is the consumer end of the execute/memory datapath.
- It latches the memory-stage result into the W pipeline register and commits valE/valM into the eight-entry program register file.
- It serves the decode stage's two combinational read ports.
- It exports W-register contents for decode forwarding, and a sticky processor-status/halt indication.

---
 rtl/w_regfile.sv | 135 +++++++++++++
 tb/tb_w_regfile.sv | 138 +++++++++++++
 2 files changed

// File: rtl/w_regfile.sv
// Y86 write-back stage: W pipeline register, eight-entry program register file,
// two combinational decode read ports and a sticky halt/status latch.
module w_regfile #(
    parameter int          NREGS     = 8,
    parameter logic [31:0] RESET_ESP = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        W_stall_i,
    input  logic        W_bubble_i,
    input  logic [3:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [31:0] M_valE_i,
    input  logic [31:0] M_valM_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [3:0]  M_dstM_i,
    input  logic [3:0]  d_srcA_i,
    input  logic [3:0]  d_srcB_i,
    output logic [31:0] d_rvalA_o,
    output logic [31:0] d_rvalB_o,
    output logic [3:0]  W_stat_o,
    output logic [3:0]  W_icode_o,
    output logic [3:0]  W_dstE_o,
    output logic [3:0]  W_dstM_o,
    output logic [31:0] W_valE_o,
    output logic [31:0] W_valM_o,
    output logic [3:0]  stat_o,
    output logic        halted_o
);

    localparam logic [3:0] STAT_AOK = 4'h1;
    localparam logic [3:0] INOP     = 4'h1;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam int         AW       = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [3:0]  w_stat_q, w_stat_d;
    logic [3:0]  w_icode_q, w_icode_d;
    logic [3:0]  w_dste_q, w_dste_d;
    logic [3:0]  w_dstm_q, w_dstm_d;
    logic [31:0] w_vale_q, w_vale_d;
    logic [31:0] w_valm_q, w_valm_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];
    logic        halted_q, halted_d;
    logic [3:0]  stat_lat_q, stat_lat_d;
    logic        wr_en;

    function automatic logic in_range(input logic [3:0] a);
        return (int'(a) < NREGS) && (a != RNONE);
    endfunction

    always_comb begin
        w_stat_d  = w_stat_q;
        w_icode_d = w_icode_q;
        w_dste_d  = w_dste_q;
        w_dstm_d  = w_dstm_q;
        w_vale_d  = w_vale_q;
        w_valm_d  = w_valm_q;
        if (!W_stall_i) begin
            if (W_bubble_i) begin
                w_stat_d  = STAT_AOK;
                w_icode_d = INOP;
                w_dste_d  = RNONE;
                w_dstm_d  = RNONE;
                w_vale_d  = 32'h0;
                w_valm_d  = 32'h0;
            end else begin
                w_stat_d  = M_stat_i;
                w_icode_d = M_icode_i;
                w_dste_d  = M_dstE_i;
                w_dstm_d  = M_dstM_i;
                w_vale_d  = M_valE_i;
                w_valm_d  = M_valM_i;
            end
        end
    end

    // A stalled W instruction commits only on the edge where W finally advances.
    assign wr_en = !halted_q && (w_stat_q == STAT_AOK) && !W_stall_i;

    always_comb begin
        regs_d = regs_q;
        if (wr_en && in_range(w_dste_q)) regs_d[w_dste_q[AW-1:0]] = w_vale_q;
        // valM written last so it wins when both destinations match.
        if (wr_en && in_range(w_dstm_q)) regs_d[w_dstm_q[AW-1:0]] = w_valm_q;
    end

    always_comb begin
        halted_d   = halted_q;
        stat_lat_d = stat_lat_q;
        if (!halted_q && (w_stat_q != STAT_AOK)) begin
            halted_d   = 1'b1;
            stat_lat_d = w_stat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            w_stat_q   <= STAT_AOK;
            w_icode_q  <= INOP;
            w_dste_q   <= RNONE;
            w_dstm_q   <= RNONE;
            w_vale_q   <= 32'h0;
            w_valm_q   <= 32'h0;
            halted_q   <= 1'b0;
            stat_lat_q <= STAT_AOK;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == 4) ? RESET_ESP : 32'h0;
            end
        end else begin
            w_stat_q   <= w_stat_d;
            w_icode_q  <= w_icode_d;
            w_dste_q   <= w_dste_d;
            w_dstm_q   <= w_dstm_d;
            w_vale_q   <= w_vale_d;
            w_valm_q   <= w_valm_d;
            halted_q   <= halted_d;
            stat_lat_q <= stat_lat_d;
            regs_q     <= regs_d;
        end
    end

    assign d_rvalA_o = in_range(d_srcA_i) ? regs_q[d_srcA_i[AW-1:0]] : 32'h0;
    assign d_rvalB_o = in_range(d_srcB_i) ? regs_q[d_srcB_i[AW-1:0]] : 32'h0;

    assign W_stat_o  = w_stat_q;
    assign W_icode_o = w_icode_q;
    assign W_dstE_o  = w_dste_q;
    assign W_dstM_o  = w_dstm_q;
    assign W_valE_o  = w_vale_q;
    assign W_valM_o  = w_valm_q;
    assign stat_o    = halted_q ? stat_lat_q : w_stat_q;
    assign halted_o  = halted_q;

endmodule

// File: tb/tb_w_regfile.sv
// Directed table-driven bench for w_regfile; each row is one clock cycle of
// inputs followed by the expected state after that rising edge.
module tb_w_regfile;

    localparam logic [31:0] ESP0 = 32'h0000_F000;

    logic        clk = 1'b0;
    logic        rst, W_stall_i, W_bubble_i;
    logic [3:0]  M_stat_i, M_icode_i, M_dstE_i, M_dstM_i, d_srcA_i, d_srcB_i;
    logic [31:0] M_valE_i, M_valM_i;
    logic [31:0] d_rvalA_o, d_rvalB_o, W_valE_o, W_valM_o;
    logic [3:0]  W_stat_o, W_icode_o, W_dstE_o, W_dstM_o, stat_o;
    logic        halted_o;

    int tests  = 0;
    int failed = 0;

    w_regfile #(.NREGS(8), .RESET_ESP(ESP0)) dut (
        .clk(clk), .rst(rst), .W_stall_i(W_stall_i), .W_bubble_i(W_bubble_i),
        .M_stat_i(M_stat_i), .M_icode_i(M_icode_i), .M_valE_i(M_valE_i),
        .M_valM_i(M_valM_i), .M_dstE_i(M_dstE_i), .M_dstM_i(M_dstM_i),
        .d_srcA_i(d_srcA_i), .d_srcB_i(d_srcB_i),
        .d_rvalA_o(d_rvalA_o), .d_rvalB_o(d_rvalB_o),
        .W_stat_o(W_stat_o), .W_icode_o(W_icode_o), .W_dstE_o(W_dstE_o),
        .W_dstM_o(W_dstM_o), .W_valE_o(W_valE_o), .W_valM_o(W_valM_o),
        .stat_o(stat_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, bubble;
        logic [3:0]  mstat, micode, mdste, mdstm, srca, srcb;
        logic [31:0] mvale, mvalm;
        logic [3:0]  e_wstat, e_wicode, e_wdste, e_wdstm, e_stat;
        logic [31:0] e_wvale, e_wvalm, e_rvala, e_rvalb;
        logic        e_halted;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic r, input logic st, input logic bu,
        input logic [3:0] ms, input logic [3:0] mi, input logic [3:0] de, input logic [3:0] dm,
        input logic [31:0] ve, input logic [31:0] vm, input logic [3:0] sa, input logic [3:0] sb,
        input logic [3:0] ews, input logic [3:0] ewi, input logic [3:0] ewde, input logic [3:0] ewdm,
        input logic [31:0] ewve, input logic [31:0] ewvm, input logic [31:0] era, input logic [31:0] erb,
        input logic [3:0] es, input logic eh);
        vec_t v;
        v.rst = r; v.stall = st; v.bubble = bu;
        v.mstat = ms; v.micode = mi; v.mdste = de; v.mdstm = dm;
        v.mvale = ve; v.mvalm = vm; v.srca = sa; v.srcb = sb;
        v.e_wstat = ews; v.e_wicode = ewi; v.e_wdste = ewde; v.e_wdstm = ewdm;
        v.e_wvale = ewve; v.e_wvalm = ewvm; v.e_rvala = era; v.e_rvalb = erb;
        v.e_stat = es; v.e_halted = eh;
        return v;
    endfunction

    initial begin
        //            rst st bu ms  mi  dE  dM  valE          valM          sA  sB   | Wst Wic WdE WdM WvalE         WvalM         rvalA         rvalB         stat h
        vecs[0]  = mk(0, 0, 0, 1, 3, 0, 4'hF, 32'h1111,     32'h0,        0, 4,      1, 1, 4'hF, 4'hF, 32'h0,        32'h0,        32'h0,        ESP0,         1, 0);
        vecs[1]  = mk(1, 0, 0, 1, 3, 0, 4'hF, 32'h12345678, 32'h0,        0, 4,      1, 3, 0, 4'hF, 32'h12345678, 32'h0,        32'h0,        ESP0,         1, 0);
        vecs[2]  = mk(1, 0, 0, 1, 4'hB, 4, 4, 32'h100,      32'h200,      0, 4,      1, 4'hB, 4, 4, 32'h100,      32'h200,      32'h12345678, ESP0,         1, 0);
        vecs[3]  = mk(1, 0, 0, 1, 5, 1, 2, 32'hAAAA,        32'hBBBB,     4, 0,      1, 5, 1, 2, 32'hAAAA,        32'hBBBB,     32'h200,      32'h12345678, 1, 0);
        vecs[4]  = mk(1, 0, 0, 1, 3, 4'hF, 4'hF, 32'h5,     32'h0,        1, 2,      1, 3, 4'hF, 4'hF, 32'h5,      32'h0,        32'hAAAA,     32'hBBBB,     1, 0);
        vecs[5]  = mk(1, 0, 0, 1, 3, 9, 4'hF, 32'h77,       32'h0,        4'hF, 9,   1, 3, 9, 4'hF, 32'h77,       32'h0,        32'h0,        32'h0,        1, 0);
        vecs[6]  = mk(1, 0, 0, 1, 3, 4'hF, 4'hF, 32'h0,     32'h0,        0, 1,      1, 3, 4'hF, 4'hF, 32'h0,      32'h0,        32'h12345678, 32'hAAAA,     1, 0);
        vecs[7]  = mk(1, 1, 0, 1, 6, 3, 4'hF, 32'h333,      32'h777,      0, 3,      1, 3, 4'hF, 4'hF, 32'h0,      32'h0,        32'h12345678, 32'h0,        1, 0);
        vecs[8]  = mk(1, 1, 1, 1, 6, 3, 4'hF, 32'h333,      32'h777,      0, 3,      1, 3, 4'hF, 4'hF, 32'h0,      32'h0,        32'h12345678, 32'h0,        1, 0);
        vecs[9]  = mk(1, 0, 1, 1, 6, 3, 4'hF, 32'h333,      32'h777,      0, 3,      1, 1, 4'hF, 4'hF, 32'h0,      32'h0,        32'h12345678, 32'h0,        1, 0);
        vecs[10] = mk(1, 0, 0, 3, 5, 4'hF, 3, 32'h0,        32'hDEAD,     3, 0,      3, 5, 4'hF, 3, 32'h0,         32'hDEAD,     32'h0,        32'h12345678, 3, 0);
        vecs[11] = mk(1, 0, 0, 1, 3, 0, 4'hF, 32'h99999999, 32'h0,        3, 0,      1, 3, 0, 4'hF, 32'h99999999, 32'h0,        32'h0,        32'h12345678, 3, 1);
        vecs[12] = mk(1, 0, 0, 1, 1, 4'hF, 4'hF, 32'h0,     32'h0,        3, 0,      1, 1, 4'hF, 4'hF, 32'h0,      32'h0,        32'h0,        32'h12345678, 3, 1);
        vecs[13] = mk(1, 0, 0, 1, 3, 0, 4'hF, 32'h55555555, 32'h0,        0, 4,      1, 3, 0, 4'hF, 32'h55555555, 32'h0,        32'h12345678, 32'h200,      3, 1);
        vecs[14] = mk(0, 0, 0, 1, 3, 2, 4'hF, 32'h42,       32'h0,        0, 4,      1, 1, 4'hF, 4'hF, 32'h0,      32'h0,        32'h0,        ESP0,         1, 0);
        vecs[15] = mk(1, 0, 0, 1, 1, 4'hF, 4'hF, 32'h0,     32'h0,        1, 2,      1, 1, 4'hF, 4'hF, 32'h0,      32'h0,        32'h0,        32'h0,        1, 0);

        rst = 1'b0; W_stall_i = 1'b0; W_bubble_i = 1'b0;
        M_stat_i = 4'h1; M_icode_i = 4'h1; M_dstE_i = 4'hF; M_dstM_i = 4'hF;
        M_valE_i = 32'h0; M_valM_i = 32'h0; d_srcA_i = 4'h0; d_srcB_i = 4'h0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; W_stall_i = vecs[i].stall; W_bubble_i = vecs[i].bubble;
            M_stat_i = vecs[i].mstat; M_icode_i = vecs[i].micode;
            M_dstE_i = vecs[i].mdste; M_dstM_i = vecs[i].mdstm;
            M_valE_i = vecs[i].mvale; M_valM_i = vecs[i].mvalm;
            d_srcA_i = vecs[i].srca; d_srcB_i = vecs[i].srcb;
            @(posedge clk);
            #1;
            chk("W_stat",  i, {28'h0, W_stat_o},  {28'h0, vecs[i].e_wstat});
            chk("W_icode", i, {28'h0, W_icode_o}, {28'h0, vecs[i].e_wicode});
            chk("W_dstE",  i, {28'h0, W_dstE_o},  {28'h0, vecs[i].e_wdste});
            chk("W_dstM",  i, {28'h0, W_dstM_o},  {28'h0, vecs[i].e_wdstm});
            chk("W_valE",  i, W_valE_o,           vecs[i].e_wvale);
            chk("W_valM",  i, W_valM_o,           vecs[i].e_wvalm);
            chk("rvalA",   i, d_rvalA_o,          vecs[i].e_rvala);
            chk("rvalB",   i, d_rvalB_o,          vecs[i].e_rvalb);
            chk("stat",    i, {28'h0, stat_o},    {28'h0, vecs[i].e_stat});
            chk("halted",  i, {31'h0, halted_o},  {31'h0, vecs[i].e_halted});
        end

        // Read ports respond without a clock edge: sweep all addresses after reset.
        for (int a = 0; a < 16; a++) begin
            logic [31:0] exp_v;
            d_srcA_i = 4'(a);
            d_srcB_i = 4'(15 - a);
            #1;
            exp_v = (a == 4) ? ESP0 : 32'h0;
            chk("sweepA", a, d_rvalA_o, exp_v);
            exp_v = ((15 - a) == 4) ? ESP0 : 32'h0;
            chk("sweepB", a, d_rvalB_o, exp_v);
        end

        // Commit then read back on ebp, and confirm the old value during the commit cycle.
        @(negedge clk);
        M_stat_i = 4'h1; M_icode_i = 4'h3; M_dstE_i = 4'h5; M_dstM_i = 4'hF;
        M_valE_i = 32'hCAFE_F00D; d_srcA_i = 4'h5;
        @(posedge clk); #1;
        chk("ebp_pre", 0, d_rvalA_o, 32'h0);
        @(negedge clk);
        M_icode_i = 4'h1; M_dstE_i = 4'hF;
        @(posedge clk); #1;
        chk("ebp_post", 0, d_rvalA_o, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
